// File: rtl/vga_text_pkg.sv
// Shared constants, state encoding and address helper for the VGA text writer.
// Cell address is {plane, row[5:0], col[5:0]}; plane 0 = char, plane 1 = attr.
package vga_text_pkg;

  localparam int COLS_DEF = 40;
  localparam int ROWS_DEF = 30;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam int ATTR_NBLINK = 7;
  localparam int ATTR_FG_HI  = 6;
  localparam int ATTR_FG_LO  = 4;
  localparam int ATTR_BRIGHT = 3;
  localparam int ATTR_BG_HI  = 2;
  localparam int ATTR_BG_LO  = 0;

  localparam int PLANE_BIT = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUT_CHAR,
    ST_PUT_ATTR,
    ST_CLR_ROW,
    ST_CLR_SCR
  } state_t;

  function automatic logic [12:0] cell_addr(
    input logic       plane,
    input logic [5:0] row,
    input logic [5:0] col
  );
    return {plane, row, col};
  endfunction

endpackage

// File: rtl/vga_cursor.sv
// Cursor column/row counters; rows wrap circularly, no scrolling.
// Strobes are mutually exclusive in practice; home has highest priority.
module vga_cursor #(
  parameter int COLS = 40,
  parameter int ROWS = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       home,
  input  logic       col_reset,
  input  logic       nl,
  output logic [5:0] col,
  output logic [5:0] row,
  output logic [5:0] row_next
);

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

  assign row_next = (row == LAST_ROW) ? 6'd0 : row + 6'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (home) begin
      col <= '0;
      row <= '0;
    end else if (nl) begin
      col <= '0;
      row <= row_next;
    end else if (inc) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= row_next;
      end else begin
        col <= col + 6'd1;
      end
    end else if (dec) begin
      col <= col - 6'd1;
    end else if (col_reset) begin
      col <= '0;
    end
  end

endmodule

// File: rtl/vga_text_writer.sv
// Byte-stream writer into the VGA text char/attr RAM write port.
// Interprets BS/LF/FF/CR, tracks cursor and attribute, clears rows/screen.
module vga_text_writer
  import vga_text_pkg::*;
#(
  parameter int         COLS           = COLS_DEF,
  parameter int         ROWS           = ROWS_DEF,
  parameter logic [7:0] ATTR_RESET     = 8'hF0,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk_20MHz,
  input  logic        n_reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  attr_in,
  input  logic        attr_we,
  output logic [7:0]  wr_data,
  output logic [12:0] wr_addr,
  output logic        wren,
  output logic [5:0]  cur_col,
  output logic [5:0]  cur_row,
  output logic        busy
);

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

  state_t     state;
  logic [7:0] attr;
  logic [7:0] snap;
  logic       adv;
  logic [5:0] clr_row;
  logic [5:0] clr_col;
  logic [5:0] row_next;

  logic accept, is_bs, is_lf, is_ff, is_cr;
  logic scr_done;

  assign accept = in_valid & in_ready;
  assign is_bs  = (in_data == CH_BS);
  assign is_lf  = (in_data == CH_LF);
  assign is_ff  = (in_data == CH_FF);
  assign is_cr  = (in_data == CH_CR);

  assign scr_done = (state == ST_CLR_SCR) && wren && wr_addr[PLANE_BIT]
                  && (clr_col == LAST_COL) && (clr_row == LAST_ROW);

  vga_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk       (clk_20MHz),
    .rst_n     (n_reset),
    .inc       ((state == ST_PUT_ATTR) && adv),
    .dec       (accept && is_bs && (cur_col != 6'd0)),
    .home      (scr_done),
    .col_reset (accept && is_cr),
    .nl        (accept && is_lf),
    .col       (cur_col),
    .row       (cur_row),
    .row_next  (row_next)
  );

  always_ff @(posedge clk_20MHz or negedge n_reset) begin
    if (!n_reset) begin
      state    <= CLEAR_ON_RESET ? ST_CLR_SCR : ST_IDLE;
      busy     <= CLEAR_ON_RESET;
      in_ready <= 1'b0;
      wren     <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      attr     <= ATTR_RESET;
      snap     <= ATTR_RESET;
      adv      <= 1'b0;
      clr_row  <= '0;
      clr_col  <= '0;
    end else begin
      if (attr_we) attr <= attr_in;
      in_ready <= 1'b0;
      busy     <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          wren     <= 1'b0;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          if (accept) begin
            snap <= attr;
            unique case (1'b1)
              is_cr: begin
                state    <= ST_PUT_ATTR;
                adv      <= 1'b0;
                in_ready <= 1'b0;
                busy     <= 1'b1;
              end
              is_lf: begin
                state    <= ST_CLR_ROW;
                clr_row  <= row_next;
                clr_col  <= '0;
                wren     <= 1'b1;
                wr_addr  <= cell_addr(1'b0, row_next, 6'd0);
                wr_data  <= CH_SPACE;
                in_ready <= 1'b0;
                busy     <= 1'b1;
              end
              is_ff: begin
                state    <= ST_CLR_SCR;
                clr_row  <= '0;
                clr_col  <= '0;
                wren     <= 1'b1;
                wr_addr  <= cell_addr(1'b0, 6'd0, 6'd0);
                wr_data  <= CH_SPACE;
                in_ready <= 1'b0;
                busy     <= 1'b1;
              end
              is_bs: begin
                if (cur_col != 6'd0) begin
                  state    <= ST_PUT_CHAR;
                  adv      <= 1'b0;
                  wren     <= 1'b1;
                  wr_addr  <= cell_addr(1'b0, cur_row, cur_col - 6'd1);
                  wr_data  <= CH_SPACE;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                end
              end
              default: begin
                state    <= ST_PUT_CHAR;
                adv      <= 1'b1;
                wren     <= 1'b1;
                wr_addr  <= cell_addr(1'b0, cur_row, cur_col);
                wr_data  <= in_data;
                in_ready <= 1'b0;
                busy     <= 1'b1;
              end
            endcase
          end
        end
        ST_PUT_CHAR: begin
          state   <= ST_PUT_ATTR;
          wren    <= 1'b1;
          wr_addr <= {1'b1, wr_addr[11:0]};
          wr_data <= snap;
        end
        ST_PUT_ATTR: begin
          if (adv && (cur_col == LAST_COL)) begin
            state   <= ST_CLR_ROW;
            clr_row <= row_next;
            clr_col <= '0;
            wren    <= 1'b1;
            wr_addr <= cell_addr(1'b0, row_next, 6'd0);
            wr_data <= CH_SPACE;
          end else begin
            state    <= ST_IDLE;
            wren     <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        ST_CLR_ROW: begin
          if (!wr_addr[PLANE_BIT]) begin
            wr_addr <= {1'b1, wr_addr[11:0]};
            wr_data <= snap;
          end else if (clr_col == LAST_COL) begin
            state    <= ST_IDLE;
            wren     <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            clr_col <= clr_col + 6'd1;
            wr_addr <= cell_addr(1'b0, clr_row, clr_col + 6'd1);
            wr_data <= CH_SPACE;
          end
        end
        ST_CLR_SCR: begin
          // wren low here only right after reset: emit the first cell
          if (!wren) begin
            wren    <= 1'b1;
            wr_addr <= cell_addr(1'b0, clr_row, clr_col);
            wr_data <= CH_SPACE;
          end else if (!wr_addr[PLANE_BIT]) begin
            wr_addr <= {1'b1, wr_addr[11:0]};
            wr_data <= snap;
          end else if (scr_done) begin
            state    <= ST_IDLE;
            wren     <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else if (clr_col == LAST_COL) begin
            clr_col <= '0;
            clr_row <= clr_row + 6'd1;
            wr_addr <= cell_addr(1'b0, clr_row + 6'd1, 6'd0);
            wr_data <= CH_SPACE;
          end else begin
            clr_col <= clr_col + 6'd1;
            wr_addr <= cell_addr(1'b0, clr_row, clr_col + 6'd1);
            wr_data <= CH_SPACE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_text_writer.sv
// Directed bench for vga_text_writer: reset clear, glyphs, control codes,
// attribute snapshot, form feed and reset during a screen clear.
module tb_vga_text_writer;

  logic        clk;
  logic        n_reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  attr_in;
  logic        attr_we;
  logic [7:0]  wr_data;
  logic [12:0] wr_addr;
  logic        wren;
  logic [5:0]  cur_col;
  logic [5:0]  cur_row;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ram [0:8191];
  int          wr_count;
  logic [12:0] first_addr;
  int          bad_row;
  bit          watch;
  logic [5:0]  watch_row;

  vga_text_writer dut (
    .clk_20MHz (clk),
    .n_reset   (n_reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .attr_in   (attr_in),
    .attr_we   (attr_we),
    .wr_data   (wr_data),
    .wr_addr   (wr_addr),
    .wren      (wren),
    .cur_col   (cur_col),
    .cur_row   (cur_row),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (n_reset && wren) begin
      ram[wr_addr] = wr_data;
      if (wr_count == 0) first_addr = wr_addr;
      wr_count = wr_count + 1;
      if (watch && (wr_addr[11:6] != watch_row)) bad_row = bad_row + 1;
    end
  end

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    bit ok;
    wait_idle(5000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout byte=%h in_ready stayed low", b);
    end
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset;
    bit ok;
    n_reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wren, wr_addr, wr_data, in_ready, busy} !== {1'b0, 13'h0, 8'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs got wren=%b addr=%h data=%h rdy=%b busy=%b want 0 0000 00 0 1",
               wren, wr_addr, wr_data, in_ready, busy);
    end
    checks++;
    if ({cur_col, cur_row} !== 12'h0) begin
      errors++;
      $display("FAIL reset_cursor got (%0d,%0d) want (0,0)", cur_col, cur_row);
    end
    wr_count = 0;
    n_reset  = 1'b1;
    wait_idle(3000, ok);
    checks++;
    if (!ok || wr_count != 2400) begin
      errors++;
      $display("FAIL reset_clear ok=%b writes=%0d want 2400", ok, wr_count);
    end
    checks++;
    if (first_addr !== 13'h0000) begin
      errors++;
      $display("FAIL reset_clear_start got %h want 0000", first_addr);
    end
    checks++;
    if (ram[13'h1767] !== 8'hF0 || ram[13'h0767] !== 8'h20) begin
      errors++;
      $display("FAIL reset_clear_last got %h/%h want 20/F0", ram[13'h0767], ram[13'h1767]);
    end
  endtask

  task automatic test_glyph;
    send(8'h41);
    @(negedge clk);
    checks++;
    if ({wren, wr_addr, wr_data, in_ready, busy} !== {1'b1, 13'h0000, 8'h41, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL glyph_char got wren=%b addr=%h data=%h rdy=%b busy=%b want 1 0000 41 0 1",
               wren, wr_addr, wr_data, in_ready, busy);
    end
    @(negedge clk);
    checks++;
    if ({wren, wr_addr, wr_data} !== {1'b1, 13'h1000, 8'hF0}) begin
      errors++;
      $display("FAIL glyph_attr got wren=%b addr=%h data=%h want 1 1000 F0", wren, wr_addr, wr_data);
    end
    @(negedge clk);
    checks++;
    if ({wren, in_ready, cur_col, cur_row} !== {1'b0, 1'b1, 6'd1, 6'd0}) begin
      errors++;
      $display("FAIL glyph_done got wren=%b rdy=%b cur=(%0d,%0d) want 0 1 (1,0)",
               wren, in_ready, cur_col, cur_row);
    end
  endtask

  task automatic test_row_wrap;
    logic [12:0] ea;
    logic [7:0]  ed;
    for (int i = 1; i < 39; i++) send((i == 1) ? 8'h00 : 8'(8'h41 + i));
    send(8'h68);
    @(negedge clk);
    checks++;
    if ({wren, wr_addr, wr_data} !== {1'b1, 13'h0027, 8'h68}) begin
      errors++;
      $display("FAIL wrap_char got %b %h %h want 1 0027 68", wren, wr_addr, wr_data);
    end
    @(negedge clk);
    checks++;
    if ({wren, wr_addr, wr_data} !== {1'b1, 13'h1027, 8'hF0}) begin
      errors++;
      $display("FAIL wrap_attr got %b %h %h want 1 1027 F0", wren, wr_addr, wr_data);
    end
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      ea = 13'h0040 + 13'(k / 2);
      ed = 8'h20;
      if (k % 2 == 1) begin
        ea = ea + 13'h1000;
        ed = 8'hF0;
      end
      checks++;
      if ({wren, wr_addr, wr_data, in_ready} !== {1'b1, ea, ed, 1'b0}) begin
        errors++;
        $display("FAIL clr_row k=%0d got %b %h %h rdy=%b want 1 %h %h 0",
                 k, wren, wr_addr, wr_data, in_ready, ea, ed);
      end
    end
    @(negedge clk);
    checks++;
    if ({wren, in_ready, cur_col, cur_row} !== {1'b0, 1'b1, 6'd0, 6'd1}) begin
      errors++;
      $display("FAIL wrap_done got wren=%b rdy=%b cur=(%0d,%0d) want 0 1 (0,1)",
               wren, in_ready, cur_col, cur_row);
    end
    checks++;
    if (ram[13'h0001] !== 8'h00 || ram[13'h0026] !== 8'h67) begin
      errors++;
      $display("FAIL wrap_ram got %h %h want 00 67", ram[13'h0001], ram[13'h0026]);
    end
  endtask

  task automatic test_cr_lf;
    bit ok;
    for (int i = 0; i < 28; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'(8'h30 + i));
    wait_idle(100, ok);
    checks++;
    if ({cur_col, cur_row} !== {6'd5, 6'd29}) begin
      errors++;
      $display("FAIL pre_cr got (%0d,%0d) want (5,29)", cur_col, cur_row);
    end
    send(8'h0D);
    @(negedge clk);
    checks++;
    if ({wren, busy, in_ready, cur_col} !== {1'b0, 1'b1, 1'b0, 6'd0}) begin
      errors++;
      $display("FAIL cr_busy got wren=%b busy=%b rdy=%b col=%0d want 0 1 0 0",
               wren, busy, in_ready, cur_col);
    end
    @(negedge clk);
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL cr_done got rdy=%b busy=%b want 1 0", in_ready, busy);
    end
    wr_count  = 0;
    bad_row   = 0;
    watch_row = 6'd0;
    watch     = 1'b1;
    send(8'h0A);
    wait_idle(200, ok);
    watch = 1'b0;
    checks++;
    if (!ok || wr_count != 80 || bad_row != 0) begin
      errors++;
      $display("FAIL lf_clear ok=%b writes=%0d off_row=%0d want 80 0", ok, wr_count, bad_row);
    end
    checks++;
    if ({cur_col, cur_row} !== 12'h0) begin
      errors++;
      $display("FAIL lf_cursor got (%0d,%0d) want (0,0)", cur_col, cur_row);
    end
    checks++;
    if (ram[13'h0740] !== 8'h30 || ram[13'h0744] !== 8'h34 || ram[13'h0000] !== 8'h20) begin
      errors++;
      $display("FAIL lf_ram got %h %h %h want 30 34 20", ram[13'h0740], ram[13'h0744], ram[13'h0000]);
    end
  endtask

  task automatic test_bs;
    send(8'h08);
    @(negedge clk);
    checks++;
    if ({wren, in_ready, cur_col, cur_row} !== {1'b0, 1'b1, 6'd0, 6'd0}) begin
      errors++;
      $display("FAIL bs_col0 got wren=%b rdy=%b cur=(%0d,%0d) want 0 1 (0,0)",
               wren, in_ready, cur_col, cur_row);
    end
    send(8'h78);
    send(8'h79);
    send(8'h7A);
    send(8'h08);
    @(negedge clk);
    checks++;
    if ({wren, wr_addr, wr_data, cur_col} !== {1'b1, 13'h0002, 8'h20, 6'd2}) begin
      errors++;
      $display("FAIL bs_char got %b %h %h col=%0d want 1 0002 20 2", wren, wr_addr, wr_data, cur_col);
    end
    @(negedge clk);
    checks++;
    if ({wren, wr_addr, wr_data} !== {1'b1, 13'h1002, 8'hF0}) begin
      errors++;
      $display("FAIL bs_attr got %b %h %h want 1 1002 F0", wren, wr_addr, wr_data);
    end
    @(negedge clk);
    checks++;
    if ({wren, in_ready, cur_col, cur_row} !== {1'b0, 1'b1, 6'd2, 6'd0}) begin
      errors++;
      $display("FAIL bs_done got wren=%b rdy=%b cur=(%0d,%0d) want 0 1 (2,0)",
               wren, in_ready, cur_col, cur_row);
    end
  endtask

  task automatic test_attr;
    bit ok;
    send(8'h42);
    @(negedge clk);
    checks++;
    if ({wren, wr_addr, wr_data} !== {1'b1, 13'h0002, 8'h42}) begin
      errors++;
      $display("FAIL attr_b_char got %b %h %h want 1 0002 42", wren, wr_addr, wr_data);
    end
    attr_in = 8'h1C;
    attr_we = 1'b1;
    @(posedge clk);
    #1 attr_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({wr_addr, wr_data} !== {13'h1002, 8'hF0}) begin
      errors++;
      $display("FAIL attr_b_snap got %h %h want 1002 F0", wr_addr, wr_data);
    end
    send(8'h43);
    repeat (2) @(negedge clk);
    checks++;
    if ({wr_addr, wr_data} !== {13'h1003, 8'h1C}) begin
      errors++;
      $display("FAIL attr_c_new got %h %h want 1003 1C", wr_addr, wr_data);
    end
    wait_idle(100, ok);
    in_data  = 8'h44;
    in_valid = 1'b1;
    attr_in  = 8'h55;
    attr_we  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    attr_we  = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({wr_addr, wr_data} !== {13'h1004, 8'h1C}) begin
      errors++;
      $display("FAIL attr_same_cycle got %h %h want 1004 1C", wr_addr, wr_data);
    end
    send(8'h45);
    repeat (2) @(negedge clk);
    checks++;
    if ({wr_addr, wr_data} !== {13'h1005, 8'h55}) begin
      errors++;
      $display("FAIL attr_e_new got %h %h want 1005 55", wr_addr, wr_data);
    end
  endtask

  task automatic test_ff;
    bit ok;
    wait_idle(100, ok);
    wr_count = 0;
    send(8'h0C);
    wait_idle(3000, ok);
    checks++;
    if (!ok || wr_count != 2400) begin
      errors++;
      $display("FAIL ff_count ok=%b writes=%0d want 2400", ok, wr_count);
    end
    checks++;
    if ({cur_col, cur_row} !== 12'h0) begin
      errors++;
      $display("FAIL ff_cursor got (%0d,%0d) want (0,0)", cur_col, cur_row);
    end
    checks++;
    if (ram[13'h1767] !== 8'h55 || ram[13'h0767] !== 8'h20 || ram[13'h0005] !== 8'h20) begin
      errors++;
      $display("FAIL ff_ram got %h %h %h want 55 20 20", ram[13'h1767], ram[13'h0767], ram[13'h0005]);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    send(8'h41);
    send(8'h0C);
    repeat (100) @(negedge clk);
    checks++;
    if (wren !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_clear_active got wren=%b busy=%b want 1 1", wren, busy);
    end
    #2 n_reset = 1'b0;
    #1;
    checks++;
    if ({wren, in_ready, cur_col, cur_row} !== {1'b0, 1'b0, 6'd0, 6'd0}) begin
      errors++;
      $display("FAIL mid_reset_async got wren=%b rdy=%b cur=(%0d,%0d) want 0 0 (0,0)",
               wren, in_ready, cur_col, cur_row);
    end
    @(negedge clk);
    wr_count = 0;
    n_reset  = 1'b1;
    @(negedge clk);
    checks++;
    if ({wren, wr_addr, wr_data} !== {1'b1, 13'h0000, 8'h20}) begin
      errors++;
      $display("FAIL restart_char got %b %h %h want 1 0000 20", wren, wr_addr, wr_data);
    end
    @(negedge clk);
    checks++;
    if ({wren, wr_addr, wr_data} !== {1'b1, 13'h1000, 8'hF0}) begin
      errors++;
      $display("FAIL restart_attr got %b %h %h want 1 1000 F0", wren, wr_addr, wr_data);
    end
    wait_idle(3000, ok);
    checks++;
    if (!ok || wr_count != 2400) begin
      errors++;
      $display("FAIL restart_count ok=%b writes=%0d want 2400", ok, wr_count);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = 8'hEE;
    n_reset    = 1'b0;
    in_data    = 8'h00;
    in_valid   = 1'b0;
    attr_in    = 8'h00;
    attr_we    = 1'b0;
    wr_count   = 0;
    first_addr = '1;
    bad_row    = 0;
    watch      = 1'b0;
    watch_row  = 6'd0;
    test_reset;
    test_glyph;
    test_row_wrap;
    test_cr_lf;
    test_bs;
    test_attr;
    test_ff;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
